// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR Fibonacci LFSR random-number generator:
// feedback tap masks, draw FSM states and parameter legality checks.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    DONE
  } draw_state_e;

  // Bit n-1 of the mask is set for tap n; XNOR-maximal sets for 3..16 bits.
  function automatic logic [15:0] taps_for(input int unsigned width);
    logic [15:0] m;
    m = '0;
    case (width)
      3:  m = 16'h0006;  // {3,2}
      4:  m = 16'h000C;  // {4,3}
      5:  m = 16'h0014;  // {5,3}
      6:  m = 16'h0030;  // {6,5}
      7:  m = 16'h0060;  // {7,6}
      8:  m = 16'h00B8;  // {8,6,5,4}
      9:  m = 16'h0110;  // {9,5}
      10: m = 16'h0240;  // {10,7}
      11: m = 16'h0500;  // {11,9}
      12: m = 16'h0829;  // {12,6,4,1}
      13: m = 16'h100D;  // {13,4,3,1}
      14: m = 16'h2015;  // {14,5,3,1}
      15: m = 16'h6000;  // {15,14}
      16: m = 16'hD008;  // {16,15,13,4}
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned range,
                                   input int unsigned base, input int unsigned out_w,
                                   input int unsigned seed);
    longint unsigned period;
    period = (64'd1 << width) - 64'd1;
    if (width < 3 || width > 16) return 1'b0;
    if (range < 1 || longint'(range) > period) return 1'b0;
    if (out_w < 1 || out_w > 32) return 1'b0;
    if (longint'(base) + longint'(range) - 64'd1 >= (64'd1 << out_w)) return 1'b0;
    if (longint'(seed) >= period) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/lfsr_rng_core.sv
// Shift register with XNOR feedback, seed load and all-ones lock-up recovery.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  SEED  = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             advance_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] state_o,
  output logic             lockup_o
);

  localparam logic [15:0] TAP_MASK = taps_for(WIDTH);

  logic [WIDTH-1:0] state_q, state_d;
  logic             lockup_q, lockup_d;
  logic             fb;

  assign fb = ~^(state_q & TAP_MASK[WIDTH-1:0]);

  always_comb begin
    state_d  = state_q;
    lockup_d = 1'b0;
    if (load_i) begin
      if (&load_val_i) begin
        state_d  = '0;
        lockup_d = 1'b1;
      end else begin
        state_d = load_val_i;
      end
    end else if (&state_q) begin
      // All-ones is a fixed point of XNOR feedback; force escape even if idle.
      state_d  = '0;
      lockup_d = 1'b1;
    end else if (advance_i) begin
      state_d = {state_q[WIDTH-2:0], fb};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SEED;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lockup_q <= lockup_d;
    end
  end

  assign state_o  = state_q;
  assign lockup_o = lockup_q;

endmodule

// File: rtl/lfsr_rng.sv
// LFSR-based secret-number source: free-running state plus a draw handshake
// returning a uniform value in [BASE, BASE+RANGE-1] by rejection sampling.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned RANGE = 10,
  parameter int unsigned BASE  = 1,
  parameter int unsigned OUT_W = 5,
  parameter int unsigned SEED  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             draw_req,
  output logic             draw_ready,
  output logic             draw_valid,
  output logic [OUT_W-1:0] draw_value,
  output logic [WIDTH-1:0] state_out,
  output logic             lockup_err
);

  if (!params_ok(WIDTH, RANGE, BASE, OUT_W, SEED)) begin : g_param_err
    $error("lfsr_rng: illegal parameter combination");
  end

  draw_state_e      fsm_q, fsm_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic [WIDTH-1:0] core_state;
  logic [31:0]      state_ext;
  logic             advance;

  assign advance = en || (fsm_q == SAMPLE);

  lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (WIDTH'(SEED))
  ) u_core (
    .clk_i      (clk),
    .rst_i      (reset),
    .advance_i  (advance),
    .load_i     (seed_load),
    .load_val_i (seed_in),
    .state_o    (core_state),
    .lockup_o   (lockup_err)
  );

  assign state_ext = 32'(core_state);

  always_comb begin
    fsm_d   = fsm_q;
    value_d = value_q;
    if (seed_load) begin
      fsm_d = IDLE;
    end else begin
      unique case (fsm_q)
        IDLE:   if (draw_req) fsm_d = SAMPLE;
        SAMPLE: begin
          if (state_ext < RANGE) begin
            value_d = OUT_W'(state_ext + BASE);
            fsm_d   = DONE;
          end
        end
        DONE:   fsm_d = IDLE;
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      value_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      value_q <= value_d;
    end
  end

  assign draw_ready = (fsm_q == IDLE);
  assign draw_valid = (fsm_q == DONE);
  assign draw_value = value_q;
  assign state_out  = core_state;

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
- Parametrised maximal-length XNOR Fibonacci LFSR with seed load and lock-up recovery.
- Adds a draw handshake that returns a uniformly distributed secret number in [BASE, BASE+RANGE-1] by rejection sampling.
- Sits between the game controller and the free-running entropy source and supplies the number the player guesses.
- The WIDTH=4 configuration has the same state sequence as the existing 4-bit generator.

Parameters:
- WIDTH, 4, LFSR state width; legal range 3..16.
- RANGE, 10, count of distinct draw values; legal range 1..2**WIDTH-1.
- BASE, 1, offset added to the accepted state to form draw_value.
- OUT_W, 5, draw_value width; must hold BASE+RANGE-1.
- SEED, 0, state loaded on reset; must not be all-ones.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  free-run advance enable.
- seed_load  in  1  load seed_in into state this cycle.
- seed_in  in  WIDTH  seed value.
- draw_req  in  1  request a new number; sampled only in IDLE.
- draw_ready  out  1  high in IDLE.
- draw_valid  out  1  one-cycle pulse: draw_value updated.
- draw_value  out  OUT_W  last accepted number; held until the next accept.
- state_out  out  WIDTH  current LFSR state.
- lockup_err  out  1  one-cycle pulse when an all-ones state is corrected.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - state=SEED, FSM=IDLE.
  - draw_valid=0, draw_value=0, lockup_err=0, draw_ready=1 on the following cycle.
- Feedback:
  - fb = XNOR of tap bits; next = {state[WIDTH-2:0], fb}.
  - Taps are 1-indexed; tap n means state[n-1].
- Sequence properties:
  - Period is 2**WIDTH-1 and covers every value except all-ones, which is the lock-up state.
  - WIDTH=4, taps {4,3}, from 0: 0,1,3,7,14,13,11,6,12,9,2,5,10,4,8,0.
- Advance condition: state advances when (en || FSM==SAMPLE) and no seed_load/reset. Otherwise it holds.
- seed_load (priority below reset):
  - state <= seed_in, or 0 if seed_in is all-ones. In the all-ones case lockup_err=1 on the next cycle.
  - Any draw in progress is aborted: FSM -> IDLE, no draw_valid, draw_value unchanged.
- Defensive recovery: if state is ever all-ones while not loading, the next state is 0 and lockup_err pulses.
- FSM states IDLE, SAMPLE, DONE:
  - IDLE: draw_ready=1. draw_req=1 -> SAMPLE.
  - SAMPLE: draw_ready=0. Each cycle evaluates the current state, then advances.
    - If state < RANGE: draw_value <= state + BASE (zero-extended to OUT_W) and -> DONE.
    - Otherwise stay in SAMPLE.
  - DONE: draw_valid=1 for exactly this cycle, draw_ready=0. -> IDLE unconditionally.
- Latency:
  - req at cycle t with k SAMPLE evaluations -> draw_valid at t+k+1.
  - Worst case k = 2**WIDTH-RANGE. Termination is guaranteed because the sequence is maximal.
- Simultaneous events:
  - draw_req outside IDLE is ignored; there is no queueing.
  - en during SAMPLE is redundant: still a single advance per cycle.
  - seed_load and draw_req in the same IDLE cycle: the load wins and the FSM stays IDLE.
- Reset mid-draw returns everything to reset values; no draw_valid is produced.

Decomposition:
- Package lfsr_pkg holds:
  - The constant tap-mask function taps_for(width), covering 3..16 as {3,2},{4,3},{5,3},{6,5},{7,6},{8,6,5,4},{9,5},{10,7},{11,9},{12,6,4,1},{13,4,3,1},{14,5,3,1},{15,14},{16,15,13,4}.
  - The FSM state enum.
  - The parameter legality checks, which raise an elaboration error when out of range.
- Sub-module lfsr_core contains the shift register, XNOR feedback, seed load and lock-up fix. lfsr_rng wraps it with the draw FSM.

Test Plan:
- Reset then en=1 for 16 cycles (WIDTH=4, SEED=0) -> state_out 0,1,3,7,14,13,11,6,12,9,2,5,10,4,8,0. Period 15, never 15.
- seed_load seed_in=7, then draw_req at t (RANGE=10, BASE=1, en=0) -> SAMPLE sees 7, accepts. draw_value=8, draw_valid high only at t+2.
- seed_load 14, draw_req at t -> SAMPLE rejects 14,13,11, accepts 6. draw_value=7, draw_valid at t+5, draw_ready low t+1..t+5.
- seed_load seed_in=4'b1111 -> state_out=0, lockup_err pulses one cycle, subsequent sequence from 0 as above.
- draw_req while in SAMPLE after seed 14, then reset asserted at t+2 -> draw_valid never pulses. Outputs return to reset values, draw_ready=1 at t+3.
- Sweep WIDTH 3..16 with en=1 for 2**WIDTH-1 cycles -> every non-all-ones value is seen exactly once, and the first revisit is the start state.
